base_stream_packer: RTL and testbench

//  Receive end of the framed 2-bit base stream (i_start/i_stop/i_A, one base per clock) that feeds PE_array.

---
 rtl/base_stream_packer.sv | 102 ++++++++++
 tb/tb_base_stream_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/base_stream_packer.sv
// rtl/base_stream_packer.sv - deserialises a framed 2-bit base stream into one packed word with valid/ready output.
// Optional build macro BSP_STRICT_EN: i_start during a frame drops that frame and flags o_err instead of restarting.
module base_stream_packer #(
  parameter int NUM_PE = 64,
  parameter int BASE_W = 2,
  parameter int LEN_W  = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [BASE_W-1:0]        i_A,
  output logic [NUM_PE*BASE_W-1:0] o_B,
  output logic [LEN_W-1:0]         o_len,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int WORD_W = NUM_PE * BASE_W;

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  slot;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    len_d   = len_q;
    valid_d = valid_q & ~i_ready;
    err_d   = 1'b0;
    slot    = cnt_q;
`ifdef BSP_STRICT_EN
    if (state_q == RECV && i_start) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else
`endif
    if (i_start || state_q == RECV) begin
      // A start always opens a clean buffer so unfilled slots read back as 0.
      if (i_start) begin
        buf_d = '0;
        slot  = '0;
      end
      for (int k = 0; k < NUM_PE; k++) begin
        if (slot == LEN_W'(k)) buf_d[k*BASE_W +: BASE_W] = i_A;
      end
      cnt_d = slot + 1'b1;
      if (i_stop || cnt_d == LEN_W'(NUM_PE)) begin
        state_d = IDLE;
        // Output register still owned by downstream: the new frame is lost.
        if (valid_q && !i_ready) begin
          err_d = 1'b1;
        end else begin
          out_d   = buf_d;
          len_d   = cnt_d;
          valid_d = 1'b1;
        end
      end else begin
        state_d = RECV;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_B     = out_q;
  assign o_len   = len_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == RECV);
  assign o_err   = err_q;

endmodule

// File: tb/tb_base_stream_packer.sv
// tb/tb_base_stream_packer.sv - scoreboard bench for base_stream_packer against a queue-based frame model.
module tb_base_stream_packer;
  localparam int NUM_PE = 64;
  localparam int BASE_W = 2;
  localparam int LEN_W  = 7;
  localparam int WW     = NUM_PE * BASE_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          ready = 1'b0;
  logic [1:0]    a = 2'd0;
  logic [WW-1:0] o_b;
  logic [LEN_W-1:0] o_len;
  logic          o_valid, o_busy, o_err;

  base_stream_packer #(.NUM_PE(NUM_PE), .BASE_W(BASE_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_A(a),
    .o_B(o_b), .o_len(o_len), .o_valid(o_valid), .i_ready(ready),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] b;
    int            len;
  } frame_t;

  int       checks = 0;
  int       fails  = 0;
  frame_t   exp_q[$];
  bit [1:0] vq[$];
  int       cur[$];
  bit       in_frame = 0;
  bit       pend = 0;

  task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic frame_t pack_cur();
    frame_t f;
    f.b = '0;
    for (int k = 0; k < cur.size(); k++) f.b[k*2 +: 2] = 2'(cur[k]);
    f.len = cur.size();
    return f;
  endfunction

  // Model: frames are lists of bases; one edge of behaviour per call.
  task automatic step(bit s, bit p, logic [1:0] base, bit r);
    bit cap = 0;
    bit err = 0;
    start = s; stop = p; a = base; ready = r;
    if (pend && r) pend = 0;
    if (s) begin
`ifdef BSP_STRICT_EN
      if (in_frame) begin
        err = 1; in_frame = 0; cur.delete();
      end else begin
        cur.delete(); cur.push_back(int'(base)); cap = 1;
      end
`else
      cur.delete(); cur.push_back(int'(base)); cap = 1;
`endif
    end else if (in_frame) begin
      cur.push_back(int'(base)); cap = 1;
    end
    if (cap) begin
      if (p || cur.size() == NUM_PE) begin
        in_frame = 0;
        if (pend) err = 1;
        else begin
          exp_q.push_back(pack_cur());
          pend = 1;
        end
      end else begin
        in_frame = 1;
      end
    end
    @(posedge clk);
    vq.push_back({pend, err});
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1; start = 0; stop = 0; a = 0; ready = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete(); vq.delete(); cur.delete();
    in_frame = 0; pend = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_len", o_len, 0);
    chk("rst_B", o_b, 0);
    chk("rst_err", o_err, 0);
  endtask

  bit [1:0]         ve;
  frame_t           fm;
  bit               hold = 0;
  logic [WW-1:0]    prev_b;
  logic [LEN_W-1:0] prev_len;

  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
    end else begin
      if (vq.size() > 0) begin
        ve = vq.pop_front();
        chk("o_valid", o_valid, ve[1]);
        chk("o_err", o_err, ve[0]);
      end
      if (hold) begin
        chk("hold_B", o_b, prev_b);
        chk("hold_len", o_len, prev_len);
      end
      hold = o_valid && !ready;
      prev_b = o_b;
      prev_len = o_len;
      if (o_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_frame: got len %0d expected none", o_len);
        end else begin
          fm = exp_q.pop_front();
          chk("o_B", o_b, fm.b);
          chk("o_len", o_len, fm.len);
        end
      end
    end
  end

  initial begin
    logic [WW-1:0] e4;
    e4 = {16{8'hE4}};
    do_reset(2);

    // Auto-close at NUM_PE bases, then a stray stop is ignored.
    for (int i = 0; i < NUM_PE; i++) begin
      step(i == 0, 0, 2'(i % 4), 0);
      if (i == 10) chk("busy_mid", o_busy, 1);
    end
    chk("auto_valid", o_valid, 1);
    chk("auto_len", o_len, 64);
    chk("auto_B", o_b, e4);
    chk("auto_busy", o_busy, 0);
    step(0, 1, 2'd1, 1);
    step(0, 0, 2'd0, 1);

    // Single-base frame.
    step(1, 1, 2'b11, 1);
    chk("one_len", o_len, 1);
    chk("one_B", o_b, 3);
    step(0, 0, 2'd0, 1);
    chk("one_fall", o_valid, 0);

    // 63-base frame held for 10 cycles.
    for (int i = 0; i < 63; i++) step(i == 0, i == 62, 2'($urandom), 0);
    chk("f63_len", o_len, 63);
    chk("f63_top", o_b[WW-1:WW-2], 0);
    repeat (10) step(0, 0, 2'd0, 0);

    // Overflow drop, then a close coinciding with acceptance.
    for (int i = 0; i < 5; i++) step(i == 0, i == 4, 2'(i + 1), 0);
    chk("ovf_err", o_err, 1);
    chk("ovf_len", o_len, 63);
    for (int i = 0; i < 5; i++) step(i == 0, i == 4, 2'(i), i == 4);
    chk("swap_err", o_err, 0);
    chk("swap_valid", o_valid, 1);
    chk("swap_len", o_len, 5);
    step(0, 0, 2'd0, 1);

    // Start arriving at base 10 of an open frame.
    for (int i = 0; i < 15; i++) step(i == 0 || i == 10, i == 14, 2'(i), 0);
`ifdef BSP_STRICT_EN
    chk("restart_valid", o_valid, 0);
`else
    chk("restart_len", o_len, 5);
`endif
    step(0, 0, 2'd0, 1);

    // Reset mid-frame with output pending.
    for (int i = 0; i < 4; i++) step(i == 0, i == 3, 2'(i), 0);
    for (int i = 0; i < 3; i++) step(i == 0, 0, 2'(i), 0);
    do_reset(1);

    repeat (300) begin
      int len, gap;
      len = $urandom_range(1, 70);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < len; i++)
        step((i == 0) || ($urandom_range(0, 40) == 0), i == len - 1,
             2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
      repeat (gap) step(0, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
    end

    repeat (3) step(0, 0, 2'd0, 1);
    chk("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
